// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // OR-encoding of a one-hot (or zero) vector; zero maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] g);
    logic [IDX_W-1:0] idx;
    idx[0] = g[1] | g[3] | g[5] | g[7];
    idx[1] = g[2] | g[3] | g[6] | g[7];
    idx[2] = g[4] | g[5] | g[6] | g[7];
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping mod 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] sel_idx
);

  logic [2*N_REQ-1:0] rot_wide;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    rot_wide = {req, req} >> ptr;
    rot      = rot_wide[N_REQ-1:0];
    found    = 1'b0;
    off      = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i[IDX_W-1:0];
      end
    end
    sel_idx = off + ptr;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with locked grants, optional hold timeout and registered outputs.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = MAX_HOLD[HOLD_W-1:0];
  // With no timeout the counter simply parks at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_SAT   = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIMIT;
  localparam logic [HOLD_W-1:0] HOLD_ONE   = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_onehot;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr),
    .found   (found),
    .sel_idx (sel_idx)
  );

  assign sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          preempt <= 1'b0;
          if (found) begin
            state     <= OWN;
            gnt       <= sel_onehot;
            gnt_idx   <= onehot_to_idx(sel_onehot);
            gnt_valid <= 1'b1;
            hold_cnt  <= HOLD_ONE;
          end
        end
        OWN: begin
          // Release takes precedence over a coincident timeout: no preempt then.
          if (!req[gnt_idx] || (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT)) begin
            state     <= IDLE;
            ptr       <= gnt_idx + 3'd1;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= req[gnt_idx];
          end else begin
            preempt <= 1'b0;
            if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
          preempt   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: owner = -1 when nobody holds the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_pre   = 0;

  rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic rs);
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (m_ptr + i) % 8;
        if (r[k] && m_owner < 0) begin
          m_owner = k;
          m_hold  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_pre = 0;
    end else if (m_hold == MAXH) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_pre = 1;
    end else begin
      m_pre = 0;
      m_hold++;
    end
  endtask

  task automatic cyc(input logic [7:0] r, input logic rs);
    logic [7:0] e_gnt;
    req   = r;
    reset = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gnt_idx", 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("gnt_valid", 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    chk("preempt", 32'(preempt), 32'(m_pre));
  endtask

  initial begin
    logic [7:0] rv;
    req   = 8'h00;
    reset = 1'b1;

    // Reset state
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    chk("reset_ptr", 32'(dut.ptr), 32'd0);
    cyc(8'h00, 1'b0);

    // Single requester 5, then release
    cyc(8'b0010_0000, 1'b0);
    chk("single_idx", 32'(gnt_idx), 32'd5);
    cyc(8'b0010_0000, 1'b0);
    cyc(8'b0000_0000, 1'b0);
    chk("single_drop_gnt", 32'(gnt), 32'd0);
    chk("single_ptr", 32'(dut.ptr), 32'd6);

    // Wrap and skip: search 6,7,0 lands on 0, next goes to 2
    cyc(8'b0000_0101, 1'b0);
    chk("wrap_idx0", 32'(gnt_idx), 32'd0);
    cyc(8'b0000_0101, 1'b0);
    cyc(8'b0000_0100, 1'b0);
    cyc(8'b0000_0100, 1'b0);
    chk("skip_idx2", 32'(gnt_idx), 32'd2);

    // Release exactly at hold_cnt == MAX_HOLD: no preempt
    cyc(8'b0000_0100, 1'b0);
    cyc(8'b0000_0100, 1'b0);
    cyc(8'b0000_0100, 1'b0);
    cyc(8'b0000_0000, 1'b0);
    chk("rel_at_to_pre", 32'(preempt), 32'd0);
    chk("rel_at_to_ptr", 32'(dut.ptr), 32'd3);

    // Lock: owner 3 keeps the grant while 1 and 7 arrive
    cyc(8'b0000_1000, 1'b0);
    cyc(8'b1000_1010, 1'b0);
    cyc(8'b1000_1010, 1'b0);
    chk("lock_gnt", 32'(gnt), 32'h08);
    cyc(8'b1000_0010, 1'b0);
    cyc(8'b1000_0010, 1'b0);
    chk("lock_next_idx7", 32'(gnt_idx), 32'd7);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // Full contention: rotation with timeout preemption
    cyc(8'h00, 1'b1);
    for (int i = 0; i < 50; i++) cyc(8'hFF, 1'b0);

    // Reset mid-grant of owner 4
    cyc(8'h00, 1'b1);
    cyc(8'h10, 1'b0);
    chk("mid_owner4", 32'(gnt_idx), 32'd4);
    cyc(8'h10, 1'b0);
    cyc(8'h10, 1'b1);
    chk("mid_rst_ptr", 32'(dut.ptr), 32'd0);
    cyc(8'hFF, 1'b0);
    chk("mid_rst_first", 32'(gnt_idx), 32'd0);

    // Random traffic with sticky requests and rare resets
    rv = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rv = 8'($urandom);
      else if ($urandom_range(5) == 0) rv = rv & ~(8'h01 << $urandom_range(7));
      cyc(rv, ($urandom_range(99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
